// File: rtl/key_debounce_sequencer_if.sv
// Key pin and debounced event bundle between a board key and its consumers.
// The bundle carries no handshake. key_in is a free-running raw level. All
// outputs are registered levels or single-cycle pulses, and consumers sample
// them on any rising clk edge without acknowledging them.
interface key_debounce_sequencer_if;
    logic       key_in;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       hold_pulse;
    logic       held;
    logic [1:0] dbg_state;

    modport master (
        output key_in,
        input  key_level, press_pulse, release_pulse, hold_pulse, held, dbg_state
    );

    modport slave (
        input  key_in,
        output key_level, press_pulse, release_pulse, hold_pulse, held, dbg_state
    );
endinterface

// File: rtl/key_debounce_sequencer.sv
// Synchronizes and debounces a raw key pin.
// Produces a clean pressed level plus press, release and long-press pulses.
module key_debounce_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    key_debounce_sequencer_if.slave kif
);
    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } state_e;

    localparam logic        REL_LVL  = ACTIVE_LOW;  // raw pin value while released
    localparam logic [19:0] DEB_END  = 20'(DEBOUNCE_CYCLES);
    localparam logic [25:0] HOLD_END = 26'(HOLD_CYCLES);
    localparam logic [25:0] HCNT_MAX = '1;

    logic        sync1_q, sync1_d, sync2_q, sync2_d;
    state_e      state_q, state_d;
    logic [19:0] dcnt_q, dcnt_d;
    logic [25:0] hcnt_q, hcnt_d;
    logic        key_level_q, key_level_d;
    logic        press_q, press_d, release_q, release_d;
    logic        hold_q, hold_d, held_q, held_d;
    logic        s;
    logic        hold_en;

    assign s = sync2_q ^ REL_LVL;

    always_comb begin
        sync1_d   = kif.key_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        hold_d    = 1'b0;
        held_d    = held_q;
        hold_en   = 1'b0;

        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_PEND;
                    dcnt_d  = 20'd1;
                end
            end
            PRESS_PEND: begin
                if (!s) begin
                    state_d = RELEASED;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_END) begin
                    state_d = PRESSED;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 20'd1;
                end
            end
            PRESSED: begin
                hold_en = 1'b1;
                if (!s) begin
                    state_d = REL_PEND;
                    dcnt_d  = 20'd1;
                end
            end
            REL_PEND: begin
                hold_en = 1'b1;
                if (s) begin
                    state_d = PRESSED;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_END) begin
                    state_d   = RELEASED;
                    dcnt_d    = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 20'd1;
                end
            end
            default: begin
                state_d = RELEASED;
                dcnt_d  = '0;
            end
        endcase

        // A release accepted on the threshold cycle suppresses the hold event.
        if (hold_en && !held_q && hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + 26'd1;
        end
        if (hold_en && !release_d && !held_q && HOLD_END != '0 && hcnt_d == HOLD_END) begin
            hold_d = 1'b1;
            held_d = 1'b1;
        end

        key_level_d = (state_d == PRESSED) || (state_d == REL_PEND);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= REL_LVL;
            sync2_q     <= REL_LVL;
            state_q     <= RELEASED;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            hold_q      <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            hold_q      <= hold_d;
            held_q      <= held_d;
        end
    end

    assign kif.key_level     = key_level_q;
    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = release_q;
    assign kif.hold_pulse    = hold_q;
    assign kif.held          = held_q;
    assign kif.dbg_state     = state_q;
endmodule
